// File: rtl/alu_seq_fsm.sv
// ALU instruction sequencer: steps one instruction through operand loads,
// execute and write-back, driving bus, ALU and register-file strobes.
module alu_seq_fsm #(
    parameter int unsigned REG_ADDR_W = 2,
    parameter int unsigned OPC_W      = 3,
    parameter int unsigned STROBE_CYC = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [OPC_W-1:0]      opcode,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  reg_out_en,
    output logic [REG_ADDR_W-1:0] reg_out_sel,
    output logic                  imm_out_en,
    output logic                  alu_a_en,
    output logic                  alu_b_en,
    output logic [OPC_W-1:0]      alu_op,
    output logic                  alu_out_en,
    output logic                  reg_dest_en,
    output logic [REG_ADDR_W-1:0] reg_dest_sel,
    output logic                  pc_inc,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned PH_W = 4;
    localparam logic [PH_W-1:0] PH_RELOAD = PH_W'(STROBE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic                  mode_q, mode_d;
    logic [OPC_W-1:0]      opc_q, opc_d;
    logic [REG_ADDR_W-1:0] rs_q, rs_d;
    logic [REG_ADDR_W-1:0] rt_q, rt_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;

    logic                  reg_out_en_d;
    logic [REG_ADDR_W-1:0] reg_out_sel_d;
    logic                  imm_out_en_d;
    logic                  alu_a_en_d;
    logic                  alu_b_en_d;
    logic [OPC_W-1:0]      alu_op_d;
    logic                  alu_out_en_d;
    logic                  reg_dest_en_d;
    logic [REG_ADDR_W-1:0] reg_dest_sel_d;
    logic                  pc_inc_d;
    logic                  busy_d;
    logic                  done_d;

    // Next state, phase counter, instruction latch and next-cycle strobes
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        mode_d         = mode_q;
        opc_d          = opc_q;
        rs_d           = rs_q;
        rt_d           = rt_q;
        rd_d           = rd_q;
        reg_out_en_d   = 1'b0;
        reg_out_sel_d  = '0;
        imm_out_en_d   = 1'b0;
        alu_a_en_d     = 1'b0;
        alu_b_en_d     = 1'b0;
        alu_op_d       = '0;
        alu_out_en_d   = 1'b0;
        reg_dest_en_d  = 1'b0;
        reg_dest_sel_d = '0;
        pc_inc_d       = 1'b0;
        busy_d         = 1'b0;
        done_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_A;
                    phase_d = PH_RELOAD;
                    mode_d  = mode;
                    opc_d   = opcode;
                    rs_d    = rs;
                    rt_d    = rt;
                    rd_d    = rd;
                end
            end
            LOAD_A: begin
                if (phase_q == '0) begin
                    state_d = LOAD_B;
                    phase_d = PH_RELOAD;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            LOAD_B: begin
                if (phase_q == '0) begin
                    state_d = EXEC;
                    phase_d = PH_RELOAD;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            EXEC: begin
                if (phase_q == '0) begin
                    state_d = WRITE;
                    phase_d = PH_RELOAD;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            WRITE: begin
                if (phase_q == '0) begin
                    state_d = DONE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase

        // Strobes are decoded from the state being entered so they register
        // in step with it; pc_inc fires only on entry into WRITE.
        case (state_d)
            LOAD_A: begin
                reg_out_en_d  = 1'b1;
                reg_out_sel_d = rs_d;
                alu_a_en_d    = 1'b1;
            end
            LOAD_B: begin
                alu_b_en_d = 1'b1;
                if (mode_d) begin
                    reg_out_en_d  = 1'b1;
                    reg_out_sel_d = rt_d;
                end else begin
                    imm_out_en_d = 1'b1;
                end
            end
            EXEC: begin
                alu_out_en_d = 1'b1;
            end
            WRITE: begin
                alu_out_en_d   = 1'b1;
                reg_dest_en_d  = 1'b1;
                reg_dest_sel_d = rd_d;
                pc_inc_d       = (state_q != WRITE);
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase

        busy_d = (state_d != IDLE);
        if (busy_d) begin
            alu_op_d = opc_d;
        end
    end

    // State, phase, latched fields and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            mode_q       <= 1'b0;
            opc_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            reg_out_en   <= 1'b0;
            reg_out_sel  <= '0;
            imm_out_en   <= 1'b0;
            alu_a_en     <= 1'b0;
            alu_b_en     <= 1'b0;
            alu_op       <= '0;
            alu_out_en   <= 1'b0;
            reg_dest_en  <= 1'b0;
            reg_dest_sel <= '0;
            pc_inc       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            mode_q       <= mode_d;
            opc_q        <= opc_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            reg_out_en   <= reg_out_en_d;
            reg_out_sel  <= reg_out_sel_d;
            imm_out_en   <= imm_out_en_d;
            alu_a_en     <= alu_a_en_d;
            alu_b_en     <= alu_b_en_d;
            alu_op       <= alu_op_d;
            alu_out_en   <= alu_out_en_d;
            reg_dest_en  <= reg_dest_en_d;
            reg_dest_sel <= reg_dest_sel_d;
            pc_inc       <= pc_inc_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

endmodule

// File: doc/alu_seq_fsm.md
ALU_SEQ_FSM -- requirements
Module: alu_seq_fsm

Interface
REQ-001 Parameter REG_ADDR_W, default 2: width of register-file select fields.
REQ-002 Parameter OPC_W, default 3: width of ALU opcode field.
REQ-003 Parameter STROBE_CYC, default 1, legal range 1..15: cycles each phase is held.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request to run one instruction; sampled only in IDLE.
REQ-007 mode  in  1  0 = immediate operand B, 1 = register operand B.
REQ-008 opcode  in  OPC_W  ALU operation.
REQ-009 rs, rt, rd  in  REG_ADDR_W each  source A, source B, destination register.
REQ-010 reg_out_en  out  1  register file drives bus.
REQ-011 reg_out_sel  out  REG_ADDR_W  register driving bus.
REQ-012 imm_out_en  out  1  immediate drives bus.
REQ-013 alu_a_en, alu_b_en  out  1 each  ALU operand A / B latch enables.
REQ-014 alu_op  out  OPC_W  latched opcode to ALU.
REQ-015 alu_out_en  out  1  ALU result drives bus.
REQ-016 reg_dest_en  out  1  register file write enable; reg_dest_sel  out  REG_ADDR_W  write target.
REQ-017 pc_inc  out  1  program-counter increment pulse.
REQ-018 busy  out  1  high in every state except IDLE; done  out  1  completion pulse.

Function
REQ-019 States: IDLE, LOAD_A, LOAD_B, EXEC, WRITE, DONE; any unused encoding SHALL transition to IDLE next cycle with all strobes low.
REQ-020 IDLE -> LOAD_A when start=1 at a rising edge; on that edge mode, opcode, rs, rt, rd SHALL be latched; otherwise remain IDLE.
REQ-021 LOAD_A, LOAD_B, EXEC, WRITE SHALL each last exactly STROBE_CYC cycles, timed by a phase counter reloaded on every state entry; order LOAD_A -> LOAD_B -> EXEC -> WRITE -> DONE.
REQ-022 DONE SHALL last exactly one cycle, then IDLE.
REQ-023 LOAD_A: reg_out_en=1, reg_out_sel=latched rs, alu_a_en=1.
REQ-024 LOAD_B, mode=0: imm_out_en=1, alu_b_en=1, reg_out_en=0; mode=1: reg_out_en=1, reg_out_sel=latched rt, alu_b_en=1, imm_out_en=0.
REQ-025 EXEC: alu_out_en=1.
REQ-026 WRITE: alu_out_en=1, reg_dest_en=1, reg_dest_sel=latched rd; pc_inc=1 only in the first WRITE cycle (one-cycle pulse regardless of STROBE_CYC).
REQ-027 DONE: done=1; all other strobes 0.
REQ-028 alu_op SHALL equal latched opcode whenever busy=1 and 0 in IDLE.
REQ-029 Strobes not listed for a state SHALL be 0; select outputs SHALL be 0 when their enable is 0.
REQ-030 Latency: with start sampled at edge E0, LOAD_A occupies cycles 1..S, LOAD_B S+1..2S, EXEC 2S+1..3S, WRITE 3S+1..4S, done in cycle 4S+1, busy low from cycle 4S+2 (S=STROBE_CYC).
REQ-031 start while busy=1 (including DONE) SHALL be ignored; a new run requires start=1 in IDLE.
REQ-032 start held continuously SHALL yield back-to-back runs with exactly one IDLE cycle between DONE and the next LOAD_A.
REQ-033 Changes on mode/opcode/rs/rt/rd while busy SHALL NOT affect the current run.
REQ-034 reg_out_en and imm_out_en SHALL never be 1 in the same cycle; at most one bus driver (reg_out_en, imm_out_en, alu_out_en) active per cycle.

Reset
REQ-035 reset=1 at a rising edge SHALL force IDLE, clear phase counter and latched fields, regardless of current state.
REQ-036 During and after reset all outputs SHALL be 0 (busy=0, done=0, selects=0, alu_op=0) until a new start.
REQ-037 start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-038 S=1, mode=0, opcode=3'b101, rs=2, rd=1, start one cycle -> cycle1 reg_out_sel=2/alu_a_en; cycle2 imm_out_en/alu_b_en; cycle3 alu_out_en, alu_op=5; cycle4 reg_dest_sel=1, pc_inc; cycle5 done; cycle6 busy=0.
REQ-039 S=1, mode=1, rs=0, rt=3, rd=2 -> cycle2 reg_out_en=1, reg_out_sel=3, imm_out_en=0; write to rd=2.
REQ-040 S=3 -> each phase 3 cycles, pc_inc exactly 1 cycle (cycle 10), done at cycle 13.
REQ-041 Inputs toggled and start re-pulsed during busy -> outputs follow first latched values, no extra run; start held high -> second LOAD_A at cycle 7 (S=1).
REQ-042 reset=1 in EXEC -> next cycle all outputs 0, IDLE; subsequent start runs normally.
REQ-043 Every cycle of all runs: assertion on REQ-034 bus exclusivity and done one-cycle width.
